clct_bx_window_best: RTL and testbench

CLCT_BX_WINDOW_BEST -- requirements
Module: clct_bx_window_best

---
 rtl/clct_bx_window_best.sv | 79 +++++++
 tb/tb_clct_bx_window_best.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/clct_bx_window_best.sv
// clct_bx_window_best: after a trigger, keeps the highest-priority CLCT seen in a W-bx window
// and holds it until acknowledged, counting the triggers lost while a result is held.
module clct_bx_window_best (
  input  logic       clock,
  input  logic       global_reset_n,
  input  logic [3:0] clct_win_best,
  input  logic [3:0] clct_pri_best,
  input  logic [3:0] pri_thresh,
  input  logic [3:0] win_width,
  input  logic       out_ack,
  input  logic       drop_cnt_clr,
  output logic       out_valid,
  output logic [3:0] out_win,
  output logic [3:0] out_pri,
  output logic [3:0] out_bx,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, OPEN, DONE} state_e;
  state_e     state_q;
  logic       valid_q;
  logic [3:0] best_pri_q, best_win_q, best_bx_q, cnt_q, weff_q;
  logic [7:0] drop_q;
  logic [3:0] thr_eff, weff_d;
  logic       trig;
  assign thr_eff = (pri_thresh == 4'd0) ? 4'd1 : pri_thresh;
  assign weff_d  = (win_width == 4'd0) ? 4'd1 : win_width;
  assign trig    = (clct_pri_best != 4'd0) && (clct_pri_best >= thr_eff);
  always_ff @(posedge clock or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      best_pri_q <= 4'd0;
      best_win_q <= 4'd0;
      best_bx_q  <= 4'd0;
      cnt_q      <= 4'd0;
      weff_q     <= 4'd0;
      drop_q     <= 8'd0;
    end else begin
      if (drop_cnt_clr) drop_q <= 8'd0;
      else if (state_q == DONE && trig && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
      case (state_q)
        IDLE: if (trig) begin
          best_pri_q <= clct_pri_best;
          best_win_q <= clct_win_best;
          best_bx_q  <= 4'd0;
          weff_q     <= weff_d;
          cnt_q      <= 4'd1;
          state_q    <= (weff_d == 4'd1) ? DONE : OPEN;
          valid_q    <= (weff_d == 4'd1);
        end
        OPEN: begin
          // strict compare: on equal priority the earlier bx is kept
          if (clct_pri_best > best_pri_q) begin
            best_pri_q <= clct_pri_best;
            best_win_q <= clct_win_best;
            best_bx_q  <= cnt_q;
          end
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == weff_q - 4'd1) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: if (out_ack) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_valid = valid_q;
  assign out_win   = best_win_q;
  assign out_pri   = best_pri_q;
  assign out_bx    = best_bx_q;
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_clct_bx_window_best.sv
// tb_clct_bx_window_best: directed window vectors from a table plus hand-written
// sequences for hold/drop counting, saturation, ack gating and mid-window reset.
module tb_clct_bx_window_best;
  logic       clock = 1'b0;
  logic       global_reset_n;
  logic [3:0] clct_win_best, clct_pri_best, pri_thresh, win_width;
  logic       out_ack, drop_cnt_clr;
  logic       out_valid, busy;
  logic [3:0] out_win, out_pri, out_bx;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  clct_bx_window_best dut (
    .clock(clock), .global_reset_n(global_reset_n),
    .clct_win_best(clct_win_best), .clct_pri_best(clct_pri_best),
    .pri_thresh(pri_thresh), .win_width(win_width),
    .out_ack(out_ack), .drop_cnt_clr(drop_cnt_clr),
    .out_valid(out_valid), .out_win(out_win), .out_pri(out_pri), .out_bx(out_bx),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  thr, thr2, wid, wid2, weff;
    logic [59:0] pri_v, win_v;
    logic [3:0]  ep, ew, eb;
  } vec_t;
  vec_t v[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // thr2/wid2 are applied after the trigger edge and must not disturb the window
    v[0] = '{thr:4'd3, thr2:4'd15, wid:4'd4, wid2:4'd0, weff:4'd4,
             pri_v:60'h000000000002553, win_v:60'h000000000001972, ep:4'd5, ew:4'd7, eb:4'd1};
    v[1] = '{thr:4'd0, thr2:4'd0, wid:4'd0, wid2:4'd0, weff:4'd1,
             pri_v:60'h4, win_v:60'hB, ep:4'd4, ew:4'd11, eb:4'd0};
    v[2] = '{thr:4'd0, thr2:4'd0, wid:4'd3, wid2:4'd3, weff:4'd3,
             pri_v:60'h201, win_v:60'h543, ep:4'd2, ew:4'd5, eb:4'd2};
    v[3] = '{thr:4'd2, thr2:4'd2, wid:4'd3, wid2:4'd3, weff:4'd3,
             pri_v:60'h344, win_v:60'h321, ep:4'd4, ew:4'd1, eb:4'd0};
    v[4] = '{thr:4'd1, thr2:4'd1, wid:4'd15, wid2:4'd15, weff:4'd15,
             pri_v:60'h711111111111111, win_v:60'hEDCBA9876543210, ep:4'd7, ew:4'd14, eb:4'd14};
    v[5] = '{thr:4'd5, thr2:4'd15, wid:4'd2, wid2:4'd1, weff:4'd2,
             pri_v:60'h65, win_v:60'h83, ep:4'd6, ew:4'd8, eb:4'd1};

    global_reset_n = 1'b0;
    clct_win_best = 0; clct_pri_best = 0; pri_thresh = 0; win_width = 0;
    out_ack = 0; drop_cnt_clr = 0;
    tick; tick;
    chk("reset_outputs", 32'({out_valid, out_win, out_pri, out_bx, busy, drop_cnt}), 0);
    global_reset_n = 1'b1;

    // first vector triggers in the first cycle after reset release
    for (int i = 0; i < 6; i++) begin
      pri_thresh = v[i].thr;
      win_width  = v[i].wid;
      for (int k = 0; k < int'(v[i].weff); k++) begin
        clct_pri_best = v[i].pri_v[4*k +: 4];
        clct_win_best = v[i].win_v[4*k +: 4];
        tick;
        if (k == 0) begin
          pri_thresh = v[i].thr2;
          win_width  = v[i].wid2;
        end
        if (k < int'(v[i].weff) - 1) chk($sformatf("v%0d_open_k%0d", i, k), 32'({out_valid, busy}), 1);
      end
      chk($sformatf("v%0d_valid", i), 32'({out_valid, busy}), 3);
      chk($sformatf("v%0d_pri", i), 32'(out_pri), 32'(v[i].ep));
      chk($sformatf("v%0d_win", i), 32'(out_win), 32'(v[i].ew));
      chk($sformatf("v%0d_bx", i), 32'(out_bx), 32'(v[i].eb));
      clct_pri_best = 0;
      out_ack = 1;
      tick;
      out_ack = 0;
      chk($sformatf("v%0d_ack", i), 32'({out_valid, busy}), 0);
    end
    chk("drop_after_vectors", 32'(drop_cnt), 0);

    // below threshold: no window; thresh 0 acts as 1
    pri_thresh = 3; win_width = 4; clct_pri_best = 2; clct_win_best = 1;
    tick;
    chk("below_thresh_busy", 32'({out_valid, busy}), 0);
    pri_thresh = 0; win_width = 0; clct_pri_best = 1; clct_win_best = 9;
    tick;
    chk("thresh0_pri1", 32'({out_valid, busy, out_pri, out_win}), 32'({2'b11, 4'd1, 4'd9}));
    clct_pri_best = 0; out_ack = 1;
    tick;
    out_ack = 0;

    // ack held high during OPEN is ignored
    pri_thresh = 1; win_width = 3; clct_pri_best = 3; clct_win_best = 6; out_ack = 1;
    tick;
    clct_pri_best = 0;
    tick;
    chk("ack_in_open", 32'({out_valid, busy}), 1);
    tick;
    chk("ack_open_result", 32'({out_valid, out_pri, out_win, out_bx}), 32'({1'b1, 4'd3, 4'd6, 4'd0}));
    tick;
    chk("ack_open_release", 32'({out_valid, busy}), 0);
    out_ack = 0;

    // held result with three lost triggers, then ack with a trigger
    pri_thresh = 1; win_width = 0; clct_pri_best = 4; clct_win_best = 11;
    tick;
    for (int c = 0; c < 10; c++) begin
      clct_pri_best = (c == 2 || c == 5 || c == 8) ? 4'd6 : 4'd0;
      clct_win_best = 4'(c);
      tick;
      chk($sformatf("hold_c%0d", c), 32'({out_valid, busy, out_pri, out_win, out_bx}),
          32'({2'b11, 4'd4, 4'd11, 4'd0}));
    end
    clct_pri_best = 0;
    chk("drop_three", 32'(drop_cnt), 3);
    out_ack = 1; clct_pri_best = 6;
    tick;
    out_ack = 0; clct_pri_best = 0;
    chk("drop_ack_trig", 32'(drop_cnt), 4);
    chk("ack_to_idle", 32'({out_valid, busy}), 0);
    clct_pri_best = 9; clct_win_best = 1;
    tick;
    chk("retrigger_after_ack", 32'({out_valid, out_pri, out_win}), 32'({1'b1, 4'd9, 4'd1}));
    clct_pri_best = 0; out_ack = 1;
    tick;
    out_ack = 0;

    // reset in the middle of a W=8 window
    win_width = 8; clct_pri_best = 5; clct_win_best = 3;
    tick;
    clct_pri_best = 7;
    tick;
    clct_pri_best = 0;
    tick;
    global_reset_n = 0;
    #1;
    chk("reset_mid_open", 32'({out_valid, out_win, out_pri, out_bx, busy, drop_cnt}), 0);
    tick;
    global_reset_n = 1;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tick;
        if (out_valid || busy) seen = 1'b1;
      end
      chk("no_result_after_reset", 32'(seen), 0);
    end

    // saturation and clear priority
    win_width = 0; clct_pri_best = 4; clct_win_best = 2;
    tick;
    repeat (300) tick;
    chk("drop_saturate", 32'({out_valid, drop_cnt}), 32'({1'b1, 8'd255}));
    drop_cnt_clr = 1;
    tick;
    drop_cnt_clr = 0;
    chk("drop_clr_wins", 32'(drop_cnt), 0);
    tick;
    chk("drop_after_clr", 32'(drop_cnt), 1);
    clct_pri_best = 0; out_ack = 1;
    tick;
    out_ack = 0;
    chk("final_idle", 32'({out_valid, busy}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
